// File: rtl/apb_slave.sv
// APB completer: MEM_DEPTH-word register file with configurable wait states and
// an error response for addresses outside the storage range.
module apb_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int MEM_DEPTH   = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslvrr
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_STATES);

    // Handshake: a transfer completes on the rising edge where psel, penable
    // and pready are all high; pslvrr and prdata are meaningful only then.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    logic             in_xfer;
    logic             access;
    logic             addr_err;
    logic             wr_en;
    logic [IDX_W-1:0] idx;

    assign idx = paddr[IDX_W-1:0];

    always_comb begin
        in_xfer  = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        access   = psel && penable;
        addr_err = ({1'b0, paddr} >= DEPTH_LIM);
        pready   = access && in_xfer && (wait_cnt_q == WAIT_LIM);
        pslvrr   = pready && addr_err;
        wr_en    = pready && pwrite && !addr_err;
        prdata   = '0;
        if (access && !pwrite && !addr_err) begin
            prdata = mem_q[idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                // penable without a preceding setup phase is ignored here
                if (psel && !penable) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (penable) begin
                    if (pready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_ACCESS;
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[idx] = pwdata;
        end
    end

    // Reset wins over a transfer completing on the same edge.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// Directed and random APB transfers against two completers (0 and 3 wait states)
// with a response queue and a reference memory image.
module tb_apb_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel_r;
  logic        penable;
  logic        pwrite;
  logic [5:0]  paddr;
  logic [31:0] pwdata;
  logic        sel3;

  logic        psel0, psel3;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3;
  logic        pslvrr0, pslvrr3;

  logic [31:0] rd;
  logic        rdy;
  logic        slverr;

  logic [32:0] exp_q[$];
  logic [31:0] mdl0 [32];
  logic [31:0] mdl3 [32];
  logic [31:0] last_rdata;
  int          total;
  int          bad;

  always #5 pclk = ~pclk;

  assign psel0  = psel_r && !sel3;
  assign psel3  = psel_r && sel3;
  assign rd     = sel3 ? prdata3 : prdata0;
  assign rdy    = sel3 ? pready3 : pready0;
  assign slverr = sel3 ? pslvrr3 : pslvrr0;

  apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .MEM_DEPTH(32), .WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslvrr(pslvrr0)
  );

  apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .MEM_DEPTH(32), .WAIT_STATES(3)) u_dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslvrr(pslvrr3)
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 32; i++) begin
      mdl0[i] = 32'h0;
      mdl3[i] = 32'h0;
    end
  endtask

  task automatic idle();
    psel_r  = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Starts just after a rising edge; leaves psel high and penable low so a
  // following call forms a back-to-back transfer.
  task automatic xfer(input bit wr, input logic [5:0] addr, input logic [31:0] data);
    logic [32:0] exp_v;
    logic [32:0] got;
    bit          err;
    bit          done;
    int          waits;
    int          exp_waits;
    err       = (addr >= 6'd32);
    exp_waits = sel3 ? 3 : 0;
    exp_v[32] = err;
    exp_v[31:0] = (!wr && !err) ? (sel3 ? mdl3[addr[4:0]] : mdl0[addr[4:0]]) : 32'h0;
    exp_q.push_back(exp_v);
    psel_r  = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    @(negedge pclk);
    chk("setup_pready", {32'h0, rdy}, 33'h0);
    @(posedge pclk); #1;
    penable = 1'b1;
    waits   = 0;
    done    = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge pclk);
      if (rdy) begin
        done = 1'b1;
        got  = {slverr, rd};
        chk("resp", got, exp_q.pop_front());
        last_rdata = rd;
      end else begin
        waits++;
      end
      @(posedge pclk); #1;
    end
    chk("done", 33'(done), 33'h1);
    chk("waits", 33'(waits), 33'(exp_waits));
    if (!done && exp_q.size() > 0) void'(exp_q.pop_front());
    if (done && wr && !err) begin
      if (sel3) mdl3[addr[4:0]] = data;
      else      mdl0[addr[4:0]] = data;
    end
    penable = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    preset  = 1'b1;
    psel_r  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    sel3    = 1'b0;
    last_rdata = '0;
    clear_models();

    // reset held for two edges
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    chk("rst_pready", {32'h0, pready0}, 33'h0);
    chk("rst_pslvrr", {32'h0, pslvrr0}, 33'h0);
    chk("rst_prdata", {1'b0, prdata0}, 33'h0);
    @(posedge pclk); #1;
    xfer(1'b0, 6'h00, 32'h0);
    chk("rst_read0", {1'b0, last_rdata}, 33'h0);
    idle();

    // write then read, no wait states
    xfer(1'b1, 6'h00, 32'hDEADBEEF);
    idle();
    xfer(1'b0, 6'h00, 32'h0);
    chk("rd_deadbeef", {1'b0, last_rdata}, {1'b0, 32'hDEADBEEF});
    idle();

    // out-of-range write and read; 0x1F must not be aliased
    xfer(1'b1, 6'h3F, 32'h55AA55AA);
    idle();
    xfer(1'b0, 6'h3F, 32'h0);
    idle();
    xfer(1'b0, 6'h1F, 32'h0);
    chk("err_no_alias", {1'b0, last_rdata}, 33'h0);
    idle();

    // three wait states
    sel3 = 1'b1;
    xfer(1'b1, 6'h1F, 32'h12345678);
    idle();
    xfer(1'b0, 6'h1F, 32'h0);
    chk("rd_ws3", {1'b0, last_rdata}, {1'b0, 32'h12345678});
    idle();

    // abort a waiting write to 0x05
    psel_r  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 6'h05;
    pwdata  = 32'hFFFFFFFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    chk("abort_w0", {32'h0, rdy}, 33'h0);
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("abort_w1", {32'h0, rdy}, 33'h0);
    @(posedge pclk); #1;
    psel_r = 1'b0;
    @(negedge pclk);
    chk("abort_rdy", {32'h0, rdy}, 33'h0);
    @(posedge pclk); #1;
    xfer(1'b0, 6'h05, 32'h0);
    chk("abort_mem", {1'b0, last_rdata}, 33'h0);
    idle();

    // back-to-back with psel held high
    sel3 = 1'b0;
    xfer(1'b1, 6'h01, 32'hA1A1A1A1);
    xfer(1'b1, 6'h02, 32'hB2B2B2B2);
    xfer(1'b0, 6'h01, 32'h0);
    chk("b2b_rd1", {1'b0, last_rdata}, {1'b0, 32'hA1A1A1A1});
    xfer(1'b0, 6'h02, 32'h0);
    chk("b2b_rd2", {1'b0, last_rdata}, {1'b0, 32'hB2B2B2B2});
    idle();

    // reset on the completing edge of a write
    psel_r  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 6'h04;
    pwdata  = 32'hA5A5A5A5;
    @(posedge pclk); #1;
    penable = 1'b1;
    preset  = 1'b1;
    @(negedge pclk);
    chk("midrst_rdy", {32'h0, rdy}, 33'h1);
    @(posedge pclk); #1;
    @(negedge pclk);
    chk("inrst_rdy", {32'h0, rdy}, 33'h0);
    @(posedge pclk); #1;
    preset  = 1'b0;
    psel_r  = 1'b0;
    penable = 1'b0;
    clear_models();
    @(posedge pclk); #1;
    xfer(1'b0, 6'h04, 32'h0);
    chk("midrst_rd4", {1'b0, last_rdata}, 33'h0);
    idle();
    sel3 = 1'b1;
    xfer(1'b0, 6'h1F, 32'h0);
    chk("rst_clr_ws3", {1'b0, last_rdata}, 33'h0);
    idle();

    // random traffic
    for (int blk = 0; blk < 10; blk++) begin
      sel3 = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) begin
        xfer(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom);
        if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
